// File: rtl/vga_scene_scheduler.sv
// VGA timing master and frame-based scene sequencer.
// Produces the raster counters, sync pulses and visible-area enable, and
// steps a scene index and a per-scene frame index at every frame wrap.
module vga_scene_scheduler #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit SYNC_ACTIVE  = 1'b0,
    parameter int SCENE_FRAMES = 256,
    parameter int NUM_SCENES   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ena,
    input  logic                                   pause,
    input  logic                                   next_scene,
    output logic [9:0]                             hpos,
    output logic [9:0]                             vpos,
    output logic                                   hsync,
    output logic                                   vsync,
    output logic                                   display_on,
    output logic                                   frame_end,
    output logic [7:0]                             frame_cnt,
    output logic [$clog2(NUM_SCENES)-1:0]          scene,
    output logic [((SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1)-1:0] scene_frame
);

    localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int SW = $clog2(NUM_SCENES);
    localparam int FW = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;

    logic [9:0]    hpos_reg;
    logic [9:0]    vpos_reg;
    logic [7:0]    frame_cnt_reg;
    logic [SW-1:0] scene_reg;
    logic [SW-1:0] scene_next;
    logic [FW-1:0] scene_frame_reg;
    logic [FW-1:0] scene_frame_next;
    logic          pending_reg;
    logic          next_scene_prev_reg;

    logic h_last;
    logic v_last;
    logic h_sync_win;
    logic v_sync_win;
    logic skip_edge;

    assign h_last     = (hpos_reg == 10'(HT - 1));
    assign v_last     = (vpos_reg == 10'(VT - 1));
    assign h_sync_win = (hpos_reg >= 10'(H_DISPLAY + H_FRONT)) &&
                        (hpos_reg <  10'(H_DISPLAY + H_FRONT + H_SYNC));
    assign v_sync_win = (vpos_reg >= 10'(V_DISPLAY + V_FRONT)) &&
                        (vpos_reg <  10'(V_DISPLAY + V_FRONT + V_SYNC));
    assign skip_edge  = next_scene && !next_scene_prev_reg;

    // Decode straight off the registered counters: no added latency.
    assign display_on  = (hpos_reg < 10'(H_DISPLAY)) && (vpos_reg < 10'(V_DISPLAY));
    assign hsync       = h_sync_win ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vsync       = v_sync_win ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign frame_end   = h_last && v_last && ena;
    assign hpos        = hpos_reg;
    assign vpos        = vpos_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign scene       = scene_reg;
    assign scene_frame = scene_frame_reg;

    // Raster counters: pixel counter wraps into the line counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_reg <= '0;
            vpos_reg <= '0;
        end else if (ena) begin
            if (h_last) begin
                hpos_reg <= '0;
                vpos_reg <= v_last ? 10'd0 : vpos_reg + 10'd1;
            end else begin
                hpos_reg <= hpos_reg + 10'd1;
            end
        end
    end

    // Scene schedule decision taken at the frame wrap; a pending skip wins
    // over both pause and a natural scene end, so they never stack.
    always_comb begin
        scene_next       = scene_reg;
        scene_frame_next = scene_frame_reg;
        if (frame_end) begin
            if (pending_reg) begin
                scene_next       = scene_reg + 1'b1;
                scene_frame_next = '0;
            end else if (!pause) begin
                if (scene_frame_reg == FW'(SCENE_FRAMES - 1)) begin
                    scene_next       = scene_reg + 1'b1;
                    scene_frame_next = '0;
                end else begin
                    scene_frame_next = scene_frame_reg + 1'b1;
                end
            end
        end
    end

    // Frame/scene state; frame_end already folds in ena, so it also freezes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg   <= '0;
            scene_reg       <= '0;
            scene_frame_reg <= '0;
        end else begin
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            scene_reg       <= scene_next;
            scene_frame_reg <= scene_frame_next;
        end
    end

    // Skip request: edge detect runs even with ena low; a fresh edge on the
    // consuming wrap re-arms pending for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg         <= 1'b0;
            next_scene_prev_reg <= 1'b0;
        end else begin
            next_scene_prev_reg <= next_scene;
            pending_reg         <= skip_edge || (pending_reg && !(frame_end));
        end
    end

endmodule

// File: tb/tb_vga_scene_scheduler.sv
// Bench for vga_scene_scheduler: a default-timing instance and a tiny-raster
// instance share stimulus; an arithmetic model (raster position from an
// enabled-cycle count) is compared every cycle, plus directed literal checks.
module tb_vga_scene_scheduler;

    logic clk, rst_n, ena, pause, next_scene;

    logic [9:0] d_h, d_v;
    logic       d_hs, d_vs, d_don, d_fe;
    logic [7:0] d_fc;
    logic [1:0] d_sc;
    logic [7:0] d_sf;

    logic [9:0] s_h, s_v;
    logic       s_hs, s_vs, s_don, s_fe;
    logic [7:0] s_fc;
    logic [1:0] s_sc;
    logic [0:0] s_sf;

    vga_scene_scheduler dut_def (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pause(pause), .next_scene(next_scene),
        .hpos(d_h), .vpos(d_v), .hsync(d_hs), .vsync(d_vs), .display_on(d_don),
        .frame_end(d_fe), .frame_cnt(d_fc), .scene(d_sc), .scene_frame(d_sf)
    );

    vga_scene_scheduler #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SCENE_FRAMES(2), .NUM_SCENES(4)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pause(pause), .next_scene(next_scene),
        .hpos(s_h), .vpos(s_v), .hsync(s_hs), .vsync(s_vs), .display_on(s_don),
        .frame_end(s_fe), .frame_cnt(s_fc), .scene(s_sc), .scene_frame(s_sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: t = enabled cycles since reset; raster position and frame
    // count follow by division, the scene rules are applied at each wrap.
    typedef struct packed {
        int t;
        int scene;
        int sframe;
        bit pend;
        bit prev;
    } mst_t;

    mst_t md, ms;

    function automatic mst_t step(input mst_t s, input int ht, input int vt,
                                  input int sfr, input int nsc,
                                  input logic en, input logic pa, input logic nsig);
        mst_t r;
        bit   edge_seen;
        r = s;
        edge_seen = nsig && !s.prev;
        if (en) begin
            if ((s.t % (ht * vt)) == ht * vt - 1) begin
                if (s.pend) begin
                    r.scene  = (s.scene + 1) % nsc;
                    r.sframe = 0;
                    r.pend   = 1'b0;
                end else if (!pa) begin
                    if (s.sframe == sfr - 1) begin
                        r.scene  = (s.scene + 1) % nsc;
                        r.sframe = 0;
                    end else begin
                        r.sframe = s.sframe + 1;
                    end
                end
            end
            r.t = s.t + 1;
        end
        if (edge_seen) r.pend = 1'b1;
        r.prev = nsig;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md <= '0;
            ms <= '0;
        end else begin
            md <= step(md, 800, 525, 256, 4, ena, pause, next_scene);
            ms <= step(ms, 11, 7, 2, 4, ena, pause, next_scene);
        end
    end

    task automatic cmp(input string tg, input mst_t m,
                       input int hd, input int hf, input int hs,
                       input int vd, input int vf, input int vs,
                       input int ht, input int vt,
                       input int h, input int v, input int hsy, input int vsy,
                       input int don, input int fe, input int fc,
                       input int sc, input int sf);
        int eh, ev;
        eh = m.t % ht;
        ev = (m.t / ht) % vt;
        check({tg, ".hpos"}, h, eh);
        check({tg, ".vpos"}, v, ev);
        check({tg, ".display_on"}, don, (eh < hd && ev < vd) ? 1 : 0);
        check({tg, ".hsync"}, hsy, (eh >= hd + hf && eh < hd + hf + hs) ? 0 : 1);
        check({tg, ".vsync"}, vsy, (ev >= vd + vf && ev < vd + vf + vs) ? 0 : 1);
        check({tg, ".frame_end"}, fe, (eh == ht - 1 && ev == vt - 1 && ena) ? 1 : 0);
        check({tg, ".frame_cnt"}, fc, (m.t / (ht * vt)) % 256);
        check({tg, ".scene"}, sc, m.scene);
        check({tg, ".scene_frame"}, sf, m.sframe);
    endtask

    bit chk_en = 1'b0;

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("def", md, 640, 16, 96, 480, 10, 2, 800, 525,
                int'(d_h), int'(d_v), int'(d_hs), int'(d_vs), int'(d_don),
                int'(d_fe), int'(d_fc), int'(d_sc), int'(d_sf));
            cmp("small", ms, 8, 1, 1, 4, 1, 1, 11, 7,
                int'(s_h), int'(s_v), int'(s_hs), int'(s_vs), int'(s_don),
                int'(s_fe), int'(s_fc), int'(s_sc), int'(s_sf));
        end
    end

    // Record the scene/scene_frame seen on each small-raster frame_end.
    bit rec_en = 1'b0;
    int seq_sc[$];
    int seq_sf[$];
    always @(negedge clk) begin
        if (rec_en && s_fe) begin
            seq_sc.push_back(int'(s_sc));
            seq_sf.push_back(int'(s_sf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_literals(input string tg);
        check({tg, ".def.hpos"}, d_h, 0);
        check({tg, ".def.vpos"}, d_v, 0);
        check({tg, ".def.display_on"}, d_don, 1);
        check({tg, ".def.hsync"}, d_hs, 1);
        check({tg, ".def.vsync"}, d_vs, 1);
        check({tg, ".def.frame_end"}, d_fe, 0);
        check({tg, ".def.frame_cnt"}, d_fc, 0);
        check({tg, ".small.hpos"}, s_h, 0);
        check({tg, ".small.vpos"}, s_v, 0);
        check({tg, ".small.scene"}, s_sc, 0);
        check({tg, ".small.scene_frame"}, s_sf, 0);
        check({tg, ".small.frame_cnt"}, s_fc, 0);
    endtask

    // Wait at negedges for the small frame_end strobe, bounded.
    task automatic wait_fe(input string tg);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_fe) begin
                ok = 1'b1;
                break;
            end
        end
        check({tg, ".wait_frame_end"}, ok, 1);
    endtask

    int exp_sc[9];
    int exp_sf[9];
    int first_low, last_low, low_cnt, don_fall, v_at, h_at;
    logic prev_don;
    int sc0, sf0, fc0;
    bit ok;

    initial begin
        rst_n = 1'b0; ena = 1'b1; pause = 1'b0; next_scene = 1'b0;
        #3;
        reset_literals("reset");
        tick();
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        rec_en = 1'b1;

        // One default line: sync window, blanking edge, line advance.
        first_low = -1; last_low = -1; low_cnt = 0; don_fall = -1;
        v_at = -1; h_at = -1; prev_don = 1'b1;
        for (int i = 0; i < 801; i++) begin
            @(negedge clk);
            if (!d_hs) begin
                if (first_low < 0) first_low = int'(d_h);
                last_low = int'(d_h);
                low_cnt++;
            end
            if (prev_don && !d_don) don_fall = int'(d_h);
            prev_don = d_don;
            if (i == 800) begin
                v_at = int'(d_v);
                h_at = int'(d_h);
            end
        end
        $display("line: hsync low %0d..%0d (%0d px), display_on falls at %0d, after wrap h=%0d v=%0d",
                 first_low, last_low, low_cnt, don_fall, h_at, v_at);
        check("hsync_first_low", first_low, 656);
        check("hsync_last_low", last_low, 751);
        check("hsync_low_count", low_cnt, 96);
        check("display_on_fall", don_fall, 640);
        check("vpos_after_line", v_at, 1);
        check("hpos_after_line", h_at, 0);

        // Natural scene rotation on the tiny raster.
        rec_en = 1'b0;
        exp_sc = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        exp_sf = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        check("rotation_frames_seen", (seq_sc.size() >= 9) ? 1 : 0, 1);
        for (int i = 0; i < 9 && i < seq_sc.size(); i++) begin
            $display("frame %0d: scene=%0d scene_frame=%0d", i, seq_sc[i], seq_sf[i]);
            check($sformatf("rotation.scene[%0d]", i), seq_sc[i], exp_sc[i]);
            check($sformatf("rotation.scene_frame[%0d]", i), seq_sf[i], exp_sf[i]);
        end

        // Pause for three frames: only frame_cnt moves.
        wait_fe("pause_sync");
        tick();
        pause = 1'b1;
        sc0 = int'(s_sc); sf0 = int'(s_sf); fc0 = int'(s_fc);
        for (int k = 0; k < 3; k++) begin
            wait_fe("pause_frame");
            tick();
        end
        $display("pause: frame_cnt %0d->%0d scene=%0d scene_frame=%0d", fc0, s_fc, s_sc, s_sf);
        check("pause.frame_cnt", s_fc, (fc0 + 3) % 256);
        check("pause.scene", s_sc, sc0);
        check("pause.scene_frame", s_sf, sf0);

        // A skip while paused still applies at the next wrap, once.
        next_scene = 1'b1; tick();
        next_scene = 1'b0; tick();
        check("pause_skip.midframe_scene", s_sc, sc0);
        wait_fe("pause_skip");
        tick();
        $display("pause skip: scene %0d->%0d scene_frame=%0d", sc0, s_sc, s_sf);
        check("pause_skip.scene", s_sc, (sc0 + 1) % 4);
        check("pause_skip.scene_frame", s_sf, 0);
        wait_fe("pause_after_skip");
        tick();
        check("pause_after_skip.scene", s_sc, (sc0 + 1) % 4);

        // Two skip edges in the last frame of a scene: exactly one advance.
        pause = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_sf == 1'b1 && s_h == 10'd2 && s_v == 10'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("double_skip.wait", ok, 1);
        tick();
        sc0 = int'(s_sc);
        next_scene = 1'b1; tick();
        next_scene = 1'b0; tick();
        tick();
        next_scene = 1'b1; tick();
        next_scene = 1'b0;
        wait_fe("double_skip");
        tick();
        $display("double skip: scene %0d->%0d scene_frame=%0d", sc0, s_sc, s_sf);
        check("double_skip.scene", s_sc, (sc0 + 1) % 4);
        check("double_skip.scene_frame", s_sf, 0);

        // Freeze on the last pixel of the frame: frame_end must stay low.
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_h == 10'd9 && s_v == 10'd6) begin
                ok = 1'b1;
                break;
            end
        end
        check("freeze.wait", ok, 1);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("freeze.small_hpos", s_h, 10);
            check("freeze.small_vpos", s_v, 6);
            check("freeze.small_frame_end", s_fe, 0);
        end
        $display("freeze: held at h=%0d v=%0d frame_end=%0d", s_h, s_v, s_fe);
        tick();
        ena = 1'b1;

        // Asynchronous reset mid-line with scene 2 showing.
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s_sc == 2'd2 && s_h == 10'd5 && s_v == 10'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("async_reset.wait", ok, 1);
        tick();
        rst_n = 1'b0;
        #1;
        $display("async reset: small h=%0d v=%0d scene=%0d, def h=%0d", s_h, s_v, s_sc, d_h);
        reset_literals("async_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scene_scheduler.md
Name: vga_scene_scheduler

Overview:
Timing master and scene sequencer for the VGA demo top level. Generates the 640x480@60 raster counters, sync pulses and the blanking enable that pace the pixel datapath. Runs a frame-based scene schedule that tells the pattern generators which effect to draw and how far into it they are. Sits directly under the tt_um top, driven by clk/rst_n/ena; the sync outputs go to uo_out.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync width
V_BACK, 33, vertical back porch
SYNC_ACTIVE, 0, asserted level of hsync/vsync
SCENE_FRAMES, 256, frames per scene (>=1)
NUM_SCENES, 4, scenes in the rotation (power of 2, >=2)

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset, active-low
ena  input  1  advance enable; 0 freezes all state
pause  input  1  holds scene_frame and scene (level)
next_scene  input  1  skip request (rising-edge sensitive)
hpos  output  10  horizontal pixel counter
vpos  output  10  line counter
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
display_on  output  1  high inside the visible area
frame_end  output  1  1-cycle strobe on the last pixel of the frame
frame_cnt  output  8  free-running frame counter
scene  output  clog2(NUM_SCENES)  current scene index
scene_frame  output  clog2(SCENE_FRAMES) (min 1)  frame index within the scene

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n). All state is in flops.
- Reset values: hpos=0, vpos=0, frame_cnt=0, scene=0, scene_frame=0, skip-pending=0, next_scene edge history=0.
- HT = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); VT = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Decode of the registered counters, valid in the same cycle as the counters, no extra latency:
  - display_on = (hpos<H_DISPLAY) && (vpos<V_DISPLAY).
  - hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC; otherwise it is the inverse.
  - vsync follows the same rule on vpos with the V_* parameters.
  - frame_end = (hpos==HT-1) && (vpos==VT-1) && ena.
- Resulting reset-time outputs: display_on=1, hsync=vsync=!SYNC_ACTIVE, frame_end=0.
- Counters, with ena=1:
  - hpos increments each cycle and wraps HT-1 -> 0.
  - vpos increments when hpos wraps, and wraps VT-1 -> 0.
  - With ena=0 every register holds. next_scene edge detection still samples, so an edge seen while ena=0 sets pending.
- The frame wrap is the cycle in which frame_end=1. On that edge:
  - frame_cnt increments mod 256, regardless of pause.
  - If skip-pending=1: scene = (scene+1) mod NUM_SCENES, scene_frame=0, pending cleared. This applies even when pause=1.
  - Else if pause=0 and scene_frame==SCENE_FRAMES-1: scene advances mod NUM_SCENES and scene_frame=0.
  - Else if pause=0: scene_frame increments.
  - Else (pause=1): scene and scene_frame hold.
- Skip request:
  - A rising edge of next_scene (registered previous value) sets skip-pending.
  - Multiple edges before the wrap coalesce into one skip.
  - An edge in the same cycle as the wrap that consumes pending sets pending again, to be applied at the following wrap.
  - A skip and a natural scene-end on the same wrap advance scene by exactly 1.
- scene and scene_frame change only at a frame wrap, never mid-frame.
- Reset asserted mid-frame returns everything to reset values immediately (asynchronously), and restarts the raster at (0,0).

Test Plan:
- Reset then run 800 cycles (defaults): hsync low exactly for hpos 656..751; display_on falls at hpos=640; vpos goes 0->1 on the cycle after hpos=799.
- Run one full frame (420000 cycles): vsync low for vpos 490..491; frame_end high only at (799,524); frame_cnt reads 1 and hpos=vpos=0 afterwards.
- Small override (H 8/1/1/1, V 4/1/1/1, SCENE_FRAMES=2, NUM_SCENES=4), 9 frames: scene sequence 0,0,1,1,2,2,3,3,0 and scene_frame alternates 0,1.
- Same override with pause=1 for 3 frames: frame_cnt +3, scene and scene_frame unchanged. One next_scene pulse while paused: scene +1 at the next frame_end, scene_frame=0.
- Two next_scene pulses in one frame, arriving when scene_frame=SCENE_FRAMES-1: scene advances by 1 only. Hold ena=0 for 50 cycles: hpos/vpos frozen, frame_end=0.
- Assert rst_n low mid-line (hpos=300, vpos=200, scene=2): all outputs return to reset values before the next clock edge.
